// File: rtl/pad_if_pkg.sv
// Shared defaults and helpers for the pad input conditioning blocks.
package pad_if_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned FILT_LEN_DEF    = 4;
   localparam int unsigned STUCK_W_DEF     = 16;
   localparam int unsigned EDGE_W_DEF      = 8;

   // All-ones value of a w-bit counter (w <= 32), used as a saturation limit.
   function automatic logic [31:0] sat_max(input int unsigned w);
      logic [32:0] one_hot;
      one_hot = 33'd1 << w;
      return 32'(one_hot - 33'd1);
   endfunction

endpackage

// File: rtl/pad_sync.sv
// Synchroniser chain for an asynchronous pad level; X/Z on the pad samples as 0.
module pad_sync
   import pad_if_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_z,
   output logic sync_out
);

   logic [STAGES-1:0] sync_q;
   logic              pad_bit_c;

   // Only a solid 1 counts as high; an unbiased (X/Z) pad reads as 0.
   assign pad_bit_c = (pad_z === 1'b1);

   // Free-running shift chain, independent of any enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pad_bit_c};
      end
   end

   assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/pad_in_filter.sv
// Pad input conditioning: synchronise, glitch-filter, edge strobes, edge counter
// and stuck-line detection. Stuck detection is built only when the macro
// PAD_IN_FILTER_STUCK_DET_EN is defined; otherwise stuck_flag is tied low.
module pad_in_filter
   import pad_if_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
   parameter int unsigned STUCK_W     = STUCK_W_DEF,
   parameter int unsigned EDGE_W      = EDGE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              pad_z,
   input  logic              stuck_clr,
   output logic              level,
   output logic              rise,
   output logic              fall,
   output logic [EDGE_W-1:0] edge_cnt,
   output logic              stuck_flag
);

   logic                sync_s;
   logic [FILT_LEN-1:0] filt_q;
   logic [FILT_LEN-1:0] filt_nxt_c;
   logic                all_hi_c;
   logic                all_lo_c;
   logic                acc_rise_c;
   logic                acc_fall_c;
   logic                acc_edge_c;

   pad_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .pad_z    (pad_z),
      .sync_out (sync_s)
   );

   // Window contents after this cycle's shift; deciding on it saves a cycle of latency.
   generate
      if (FILT_LEN == 1) begin : g_filt_one
         assign filt_nxt_c = sync_s;
      end else begin : g_filt_many
         assign filt_nxt_c = {filt_q[FILT_LEN-2:0], sync_s};
      end
   endgenerate

   assign all_hi_c   = &filt_nxt_c;
   assign all_lo_c   = ~|filt_nxt_c;
   assign acc_rise_c = en & all_hi_c & ~level;
   assign acc_fall_c = en & all_lo_c & level;
   assign acc_edge_c = acc_rise_c | acc_fall_c;

   // Sample window, frozen while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= '0;
      end else if (en) begin
         filt_q <= filt_nxt_c;
      end
   end

   // Accepted level and single-cycle strobes; strobes drop to 0 whenever en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= acc_rise_c;
         fall <= acc_fall_c;
         if (acc_edge_c) begin
            level <= ~level;
         end
      end
   end

   // Wrapping count of accepted edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt <= '0;
      end else if (acc_edge_c) begin
         edge_cnt <= edge_cnt + EDGE_W'(1);
      end
   end

`ifdef PAD_IN_FILTER_STUCK_DET_EN

   localparam logic [STUCK_W-1:0] IDLE_MAX = STUCK_W'(sat_max(STUCK_W));

   logic [STUCK_W-1:0] idle_q;
   logic [STUCK_W-1:0] idle_nxt_c;
   logic               stuck_set_c;

   // Idle counter next value: restart on an accepted edge, else count up to saturation.
   always_comb begin
      idle_nxt_c  = idle_q;
      stuck_set_c = 1'b0;
      if (en) begin
         if (acc_edge_c) begin
            idle_nxt_c = '0;
         end else if (idle_q != IDLE_MAX) begin
            idle_nxt_c = idle_q + STUCK_W'(1);
         end
         stuck_set_c = (idle_nxt_c == IDLE_MAX);
      end
   end

   // Sticky stuck flag; a clear request beats a coincident set and acts even when disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q     <= '0;
         stuck_flag <= 1'b0;
      end else if (stuck_clr) begin
         idle_q     <= '0;
         stuck_flag <= 1'b0;
      end else begin
         idle_q <= idle_nxt_c;
         if (stuck_set_c) begin
            stuck_flag <= 1'b1;
         end
      end
   end

`else

   // Stuck detection not built: flag constant low, clear input and width unused.
   logic               unused_stuck_clr;
   logic [STUCK_W-1:0] unused_stuck_w;

   assign unused_stuck_clr = stuck_clr;
   assign unused_stuck_w   = '0;
   assign stuck_flag       = 1'b0;

`endif

endmodule

// File: tb/tb_pad_in_filter.sv
// Self-checking bench for pad_in_filter (stuck checks follow PAD_IN_FILTER_STUCK_DET_EN).
module tb_pad_in_filter;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned FILT_LEN    = 4;
   localparam int unsigned STUCK_W     = 4;
   localparam int unsigned EDGE_W      = 8;
   localparam int          LAT         = SYNC_STAGES + FILT_LEN;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              pad_z;
   logic              stuck_clr;
   logic              level;
   logic              rise;
   logic              fall;
   logic [EDGE_W-1:0] edge_cnt;
   logic              stuck_flag;

   pad_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .STUCK_W     (STUCK_W),
      .EDGE_W      (EDGE_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pad_z      (pad_z),
      .stuck_clr  (stuck_clr),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .edge_cnt   (edge_cnt),
      .stuck_flag (stuck_flag)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_rise = 0;
   int n_fall = 0;
   int n_both = 0;

   typedef struct packed {
      logic              r;
      logic              f;
      logic              lvl;
      logic [EDGE_W-1:0] cnt;
   } ev_t;

   ev_t               exp_q[$];
   logic              m_lvl;
   logic [EDGE_W-1:0] m_cnt;

   // Strobe counters sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (rise === 1'b1) n_rise++;
      if (fall === 1'b1) n_fall++;
      if (rise === 1'b1 && fall === 1'b1) n_both++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset;
      m_lvl = 1'b0;
      m_cnt = '0;
      exp_q.delete();
   endtask

   // Record the strobe/level/count an accepted pad transition must produce.
   task automatic push_edge;
      m_lvl = ~m_lvl;
      m_cnt = m_cnt + 8'd1;
      exp_q.push_back({m_lvl, ~m_lvl, m_lvl, m_cnt});
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst       = 1'b1;
      pad_z     = 1'b0;
      stuck_clr = 1'b0;
      tick(2);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_strobe(input int bound, output int cyc, output bit got);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (rise === 1'b1 || fall === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; pad_z = 1'b0; stuck_clr = 1'b0;
      model_reset();
      tick(3);
      n_chk++;
      if ({level, rise, fall, edge_cnt, stuck_flag} !== '0) begin
         n_fail++;
         $display("FAIL reset_in: lvl=%b r=%b f=%b cnt=%h stuck=%b, need all 0",
                  level, rise, fall, edge_cnt, stuck_flag);
      end
      rst = 1'b0;
      tick(3);
      n_chk++;
      if ({level, rise, fall, edge_cnt, stuck_flag} !== '0) begin
         n_fail++;
         $display("FAIL reset_out: lvl=%b r=%b f=%b cnt=%h stuck=%b, need all 0",
                  level, rise, fall, edge_cnt, stuck_flag);
      end
   endtask

   task automatic test_rise_latency;
      int cyc; bit got; ev_t e;
      en = 1'b1;
      do_reset();
      tick(4);
      pad_z = 1'b1;
      push_edge();
      wait_strobe(LAT + 4, cyc, got);
      n_chk++;
      if (!got || cyc < LAT - 1 || cyc > LAT + 1) begin
         n_fail++;
         $display("FAIL rise_latency: strobe=%0b after %0d cycles, need %0d..%0d", got, cyc, LAT - 1, LAT + 1);
      end
      if (got && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if ({rise, fall, level, edge_cnt} !== e) begin
            n_fail++;
            $display("FAIL rise_event: got %h, need %h", {rise, fall, level, edge_cnt}, e);
         end
      end
      tick(1);
      n_chk++;
      if ({rise, fall, level, edge_cnt} !== {2'b00, 1'b1, 8'd1}) begin
         n_fail++;
         $display("FAIL rise_single: r=%b f=%b lvl=%b cnt=%0d, need 0 0 1 1", rise, fall, level, edge_cnt);
      end
   endtask

   task automatic test_glitch;
      int cyc; bit got; ev_t e; int r0; int f0;
      en = 1'b1;
      do_reset();
      tick(4);
      r0 = n_rise; f0 = n_fall;
      pad_z = 1'b1;
      tick(FILT_LEN - 1);
      pad_z = 1'b0;
      tick(12);
      n_chk++;
      if (n_rise != r0 || n_fall != f0 || {level, edge_cnt} !== '0) begin
         n_fail++;
         $display("FAIL glitch_reject: rises=%0d falls=%0d lvl=%b cnt=%0d, need 0 0 0 0",
                  n_rise - r0, n_fall - f0, level, edge_cnt);
      end
      pad_z = 1'b1;
      push_edge();
      tick(FILT_LEN);
      pad_z = 1'b0;
      push_edge();
      for (int i = 0; i < 2; i++) begin
         wait_strobe(LAT + 6, cyc, got);
         n_chk++;
         if (!got || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_strobe: strobe=%0b queued=%0d, need a strobe", got, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            n_chk++;
            if ({rise, fall, level, edge_cnt} !== e) begin
               n_fail++;
               $display("FAIL pulse_event%0d: got %h, need %h", i, {rise, fall, level, edge_cnt}, e);
            end
         end
      end
      n_chk++;
      if (n_both != 0) begin
         n_fail++;
         $display("FAIL both_strobes: %0d cycles with rise and fall, need 0", n_both);
      end
   endtask

   task automatic test_wrap;
      int cyc; bit got; ev_t e;
      en = 1'b1;
      do_reset();
      tick(4);
      for (int i = 0; i < 256; i++) begin
         pad_z = ~pad_z;
         push_edge();
         wait_strobe(LAT + 4, cyc, got);
         n_chk++;
         if (!got || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wrap_strobe%0d: strobe=%0b, need a strobe", i, got);
         end else begin
            e = exp_q.pop_front();
            n_chk++;
            if ({rise, fall, level, edge_cnt} !== e) begin
               n_fail++;
               $display("FAIL wrap_event%0d: got %h, need %h", i, {rise, fall, level, edge_cnt}, e);
            end
         end
         tick(2);
      end
      n_chk++;
      if ({level, edge_cnt} !== '0) begin
         n_fail++;
         $display("FAIL wrap_final: lvl=%b cnt=%0d, need 0 0", level, edge_cnt);
      end
   endtask

   task automatic test_en_freeze;
      int cyc; bit got; ev_t e; int r0; int f0;
      en = 1'b1;
      tick(6);
      en = 1'b0;
      r0 = n_rise; f0 = n_fall;
      for (int i = 0; i < 20; i++) begin
         pad_z = ~pad_z;
         tick(1);
      end
      pad_z = 1'b1;
      tick(SYNC_STAGES + 2);
      n_chk++;
      if (n_rise != r0 || n_fall != f0 || {level, edge_cnt} !== {m_lvl, m_cnt}) begin
         n_fail++;
         $display("FAIL en_freeze: rises=%0d falls=%0d lvl=%b cnt=%0d, need 0 0 %b %0d",
                  n_rise - r0, n_fall - f0, level, edge_cnt, m_lvl, m_cnt);
      end
      en = 1'b1;
      push_edge();
      wait_strobe(FILT_LEN, cyc, got);
      n_chk++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL reenable_strobe: strobe=%0b within %0d cycles, need 1", got, FILT_LEN);
      end else begin
         e = exp_q.pop_front();
         n_chk++;
         if ({rise, fall, level, edge_cnt} !== e) begin
            n_fail++;
            $display("FAIL reenable_event: got %h, need %h", {rise, fall, level, edge_cnt}, e);
         end
      end
   endtask

   task automatic test_stuck;
`ifdef PAD_IN_FILTER_STUCK_DET_EN
      int cyc; bit got; ev_t e;
      logic [3:0] obs;
      en = 1'b1;
      do_reset();
      tick(14);
      obs[0] = stuck_flag;
      tick(1);
      obs[1] = stuck_flag;
      stuck_clr = 1'b1;
      tick(1);
      stuck_clr = 1'b0;
      obs[2] = stuck_flag;
      tick(14);
      obs[3] = stuck_flag;
      n_chk++;
      if (obs !== 4'b0010) begin
         n_fail++;
         $display("FAIL stuck_set_clr: flags(14,15,clr,14)=%b, need 0,1,0,0", {obs[0], obs[1], obs[2], obs[3]});
      end
      stuck_clr = 1'b1;
      tick(1);
      stuck_clr = 1'b0;
      obs[0] = stuck_flag;
      tick(14);
      obs[1] = stuck_flag;
      tick(1);
      obs[2] = stuck_flag;
      n_chk++;
      if (obs[2:0] !== 3'b100) begin
         n_fail++;
         $display("FAIL stuck_clr_wins: flags(sat+clr,14,15)=%b%b%b, need 0,0,1", obs[0], obs[1], obs[2]);
      end
      pad_z = 1'b1;
      push_edge();
      wait_strobe(LAT + 4, cyc, got);
      n_chk++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL stuck_edge_strobe: strobe=%0b, need 1", got);
      end else begin
         e = exp_q.pop_front();
         n_chk++;
         if ({rise, fall, level, edge_cnt, stuck_flag} !== {e, 1'b1}) begin
            n_fail++;
            $display("FAIL stuck_sticky: got %h, need %h", {rise, fall, level, edge_cnt, stuck_flag}, {e, 1'b1});
         end
      end
      tick(20);
      en = 1'b0;
      stuck_clr = 1'b1;
      tick(1);
      stuck_clr = 1'b0;
      n_chk++;
      if (stuck_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_clr_disabled: flag=%b, need 0", stuck_flag);
      end
      en = 1'b1;
`else
      en = 1'b1;
      do_reset();
      tick(40);
      n_chk++;
      if (stuck_flag !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_tied: flag=%b, need 0", stuck_flag);
      end
`endif
   endtask

   task automatic test_x_reset;
      int cyc; bit got; ev_t e; int r0; int f0;
      en = 1'b1;
      pad_z = 1'b1;
      tick(LAT + 4);
      n_chk++;
      if (level !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_level: lvl=%b, need 1", level);
      end
      pad_z = 1'b0;
      tick(2);
      pad_z = 1'bx;
      tick(1);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({level, rise, fall, edge_cnt, stuck_flag} !== '0 ||
          $isunknown({level, rise, fall, edge_cnt, stuck_flag})) begin
         n_fail++;
         $display("FAIL async_reset: lvl=%b r=%b f=%b cnt=%h stuck=%b, need all 0",
                  level, rise, fall, edge_cnt, stuck_flag);
      end
      model_reset();
      tick(1);
      rst = 1'b0;
      pad_z = 1'bz;
      r0 = n_rise; f0 = n_fall;
      tick(3);
      pad_z = 1'b0;
      tick(LAT + 1);
      n_chk++;
      if (n_rise != r0 || n_fall != f0 || {level, edge_cnt} !== '0 ||
          $isunknown({level, rise, fall, edge_cnt, stuck_flag})) begin
         n_fail++;
         $display("FAIL xz_pad: rises=%0d falls=%0d lvl=%b cnt=%0d, need 0 0 0 0",
                  n_rise - r0, n_fall - f0, level, edge_cnt);
      end
      pad_z = 1'b1;
      push_edge();
      wait_strobe(LAT + 4, cyc, got);
      n_chk++;
      if (!got || cyc < LAT - 1 || cyc > LAT + 1 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL post_reset_latency: strobe=%0b after %0d cycles, need %0d..%0d", got, cyc, LAT - 1, LAT + 1);
      end else begin
         e = exp_q.pop_front();
         n_chk++;
         if ({rise, fall, level, edge_cnt} !== e) begin
            n_fail++;
            $display("FAIL post_reset_event: got %h, need %h", {rise, fall, level, edge_cnt}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rise_latency();
      test_glitch();
      test_wrap();
      test_en_freeze();
      test_stuck();
      test_x_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
